tdc_pair_scheduler: RTL and testbench
=====================================

TDC_PAIR_SCHEDULER -- requirements
Module: tdc_pair_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4: number of TDC channels sharing the pair differencer.
REQ-002 SHALL have parameter W, default 37: timestamp width.
REQ-003 SHALL have parameter SETTLE, default 3: idle cycles after each issued pair, range 1..255.
REQ-004 SHALL have parameter TMO, default 1000: cycles a lone start may wait for its stop, range 1..65535.
REQ-005 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1: when low, no new grant is made; buffering continues.
REQ-008 SHALL have port ch_dval, input, NCH: per-channel one-cycle timestamp strobe.
REQ-009 SHALL have port ch_data, input, NCH*W: per-channel timestamp; channel k occupies bits [k*W+W-1:k*W].
REQ-010 SHALL have port mux_dval, output, 1: strobe to the shared differencer.
REQ-011 SHALL have port mux_data, output, W: timestamp to the differencer.
REQ-012 SHALL have port mux_ch, output, clog2(NCH): channel tag of the pair in flight.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port tmo_pulse, output, NCH: one-cycle pulse when a channel's lone start is discarded.
REQ-015 SHALL have port ovf_cnt, output, NCH*8: per-channel saturating count of dropped timestamps.

Function
REQ-016 SHALL give each channel a two-word buffer with states EMPTY, HALF (start held), FULL (start+stop held).
REQ-017 SHALL, on ch_dval[k]: EMPTY->HALF storing start; HALF->FULL storing stop; FULL: drop the sample and increment ovf_cnt[k], saturating at 255.
REQ-018 SHALL run a per-channel timer in HALF; at TMO cycles without a stop, return to EMPTY and pulse tmo_pulse[k]; a ch_dval in the expiry cycle is taken as the stop (FULL), with no pulse.
REQ-019 SHALL run an FSM with states IDLE, SEND_START, SEND_STOP, SETTLE.
REQ-020 SHALL, in IDLE with en high and at least one FULL channel, grant the FULL channel nearest after last_grant in round-robin order (last_grant resets to NCH-1, so channel 0 wins first).
REQ-021 SHALL, in the grant cycle, copy both words into hold registers, set the channel EMPTY and go to SEND_START; a ch_dval on that channel in the same cycle leaves it HALF with the new start.
REQ-022 SHALL in SEND_START drive mux_dval=1, mux_data=start, mux_ch=grant, then go to SEND_STOP.
REQ-023 SHALL in SEND_STOP drive mux_dval=1, mux_data=stop, mux_ch unchanged, then go to SETTLE.
REQ-024 SHALL in SETTLE hold mux_dval=0 for SETTLE cycles, then go to IDLE; mux_ch holds until the next grant.
REQ-025 SHALL register all outputs; grant-cycle-to-first-strobe latency is 1 cycle; minimum pair period is 3+SETTLE cycles.
REQ-026 SHALL pass timestamps unmodified, with no arithmetic on data; pairs never interleave between channels.
REQ-027 SHALL let en going low mid-pair finish the current pair; it blocks only the next grant.

Reset
REQ-028 SHALL, while rst is low, force FSM=IDLE, all buffers EMPTY, timers=0, last_grant=NCH-1, mux_dval=0, mux_data=0, mux_ch=0, busy=0, tmo_pulse=0, ovf_cnt=0.
REQ-029 SHALL, on rst assertion mid-pair, abort immediately with no further mux_dval strobe after release.

Verification
REQ-030 SHALL test single pair: ch0 dval 0x10 then 0x25 -> mux_dval at t+1 and t+2 with data 0x10, 0x25, mux_ch=0, then busy low after 3 settle cycles.
REQ-031 SHALL test fairness: all 4 channels FULL at once -> issue order 0,1,2,3; refill all -> order 0,1,2,3 again.
REQ-032 SHALL test overflow: ch2 gets 5 strobes while en=0 -> ovf_cnt[2]=3; after en=1, first two samples issued; 300 extra drops -> ovf_cnt=255.
REQ-033 SHALL test timeout with TMO=10: ch1 start only -> tmo_pulse[1] after 10 cycles, buffer EMPTY; stop on the 10th cycle -> FULL, no pulse.
REQ-034 SHALL test grant collision: ch3 dval in its grant cycle -> new start retained (HALF); pair data unaffected.
REQ-035 SHALL test rst low during SEND_START -> all outputs zero, no SEND_STOP strobe after release.

Source files
------------

// File: rtl/tdc_pair_scheduler.sv
// tdc_pair_scheduler
// Buffers start/stop timestamp pairs from NCH TDC channels and issues them,
// one complete pair at a time, to a single shared differencer. Channels are
// served round-robin. A start that waits too long for its stop is discarded,
// and samples that arrive while a channel already holds a full pair are counted.
module tdc_pair_scheduler #(
    parameter int NCH    = 4,
    parameter int W      = 37,
    parameter int SETTLE = 3,
    parameter int TMO    = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NCH-1:0]            ch_dval,
    input  logic [NCH*W-1:0]          ch_data,
    output logic                      mux_dval,
    output logic [W-1:0]              mux_data,
    output logic [$clog2(NCH)-1:0]    mux_ch,
    output logic                      busy,
    output logic [NCH-1:0]            tmo_pulse,
    output logic [NCH*8-1:0]          ovf_cnt
);

    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND_START,
        ST_SEND_STOP,
        ST_SETTLE
    } fsm_t;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_HALF,
        BUF_FULL
    } buf_t;

    fsm_t            state_reg;
    fsm_t            state_next;
    logic [CW-1:0]   last_grant_reg;
    logic [CW-1:0]   grant_idx;
    logic            grant_found;
    logic            grant_fire;
    logic [7:0]      settle_cnt_reg;
    logic [W-1:0]    hold_stop_reg;
    logic [NCH-1:0]  full_vec;
    logic [NCH*W-1:0] start_all;
    logic [NCH*W-1:0] stop_all;

    // Round-robin search: first FULL channel strictly after the last grant.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last_grant_reg) + i) % NCH;
            if (!grant_found && full_vec[CW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = CW'(idx);
            end
        end
        grant_fire = grant_found && en && (state_reg == ST_IDLE);
    end

    // Next-state logic for the pair-issue sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:       if (grant_fire) state_next = ST_SEND_START;
            ST_SEND_START: state_next = ST_SEND_STOP;
            ST_SEND_STOP:  state_next = ST_SETTLE;
            ST_SETTLE:     if (settle_cnt_reg == 8'(SETTLE - 1)) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // Sequencer state and registered outputs; outputs are loaded one edge ahead
    // so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= CW'(NCH - 1);
            settle_cnt_reg <= '0;
            hold_stop_reg  <= '0;
            mux_dval       <= 1'b0;
            mux_data       <= '0;
            mux_ch         <= '0;
            busy           <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy      <= (state_next != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (grant_fire) begin
                        mux_dval       <= 1'b1;
                        mux_data       <= start_all[grant_idx*W +: W];
                        mux_ch         <= grant_idx;
                        last_grant_reg <= grant_idx;
                        // The channel buffer may refill next cycle, so keep the stop here.
                        hold_stop_reg  <= stop_all[grant_idx*W +: W];
                    end
                end
                ST_SEND_START: begin
                    mux_dval <= 1'b1;
                    mux_data <= hold_stop_reg;
                end
                ST_SEND_STOP: begin
                    mux_dval       <= 1'b0;
                    settle_cnt_reg <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg + 8'd1;
                end
                default: begin
                    mux_dval <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel two-word buffer, start timeout and overflow counter.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        buf_t          buf_reg;
        logic [W-1:0]  start_reg;
        logic [W-1:0]  stop_reg;
        logic [15:0]   timer_reg;
        logic [7:0]    ovf_reg;
        logic          tmo_reg;
        logic          take;
        logic          dval;
        logic [W-1:0]  data;

        assign take = grant_fire && (grant_idx == CW'(gi));
        assign dval = ch_dval[gi];
        assign data = ch_data[gi*W +: W];

        // Buffer state machine; a grant empties the buffer, a new sample in the
        // same cycle becomes the next start.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                buf_reg   <= BUF_EMPTY;
                start_reg <= '0;
                stop_reg  <= '0;
                timer_reg <= '0;
                ovf_reg   <= '0;
                tmo_reg   <= 1'b0;
            end else begin
                tmo_reg <= 1'b0;
                case (buf_reg)
                    BUF_EMPTY: begin
                        if (dval) begin
                            buf_reg   <= BUF_HALF;
                            start_reg <= data;
                            timer_reg <= '0;
                        end
                    end
                    BUF_HALF: begin
                        if (dval) begin
                            buf_reg  <= BUF_FULL;
                            stop_reg <= data;
                        end else if (timer_reg == 16'(TMO - 1)) begin
                            buf_reg <= BUF_EMPTY;
                            tmo_reg <= 1'b1;
                        end else begin
                            timer_reg <= timer_reg + 16'd1;
                        end
                    end
                    BUF_FULL: begin
                        if (take) begin
                            if (dval) begin
                                buf_reg   <= BUF_HALF;
                                start_reg <= data;
                                timer_reg <= '0;
                            end else begin
                                buf_reg <= BUF_EMPTY;
                            end
                        end else if (dval && (ovf_reg != 8'hFF)) begin
                            ovf_reg <= ovf_reg + 8'd1;
                        end
                    end
                    default: buf_reg <= BUF_EMPTY;
                endcase
            end
        end

        assign full_vec[gi]          = (buf_reg == BUF_FULL);
        assign start_all[gi*W +: W]  = start_reg;
        assign stop_all[gi*W +: W]   = stop_reg;
        assign ovf_cnt[gi*8 +: 8]    = ovf_reg;
        assign tmo_pulse[gi]         = tmo_reg;
    end

endmodule

// File: tb/tb_tdc_pair_scheduler.sv
// Directed bench for tdc_pair_scheduler with a scoreboard of expected strobes.
module tb_tdc_pair_scheduler;

    localparam int NCH = 4;
    localparam int W   = 37;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [NCH-1:0]       ch_dval;
    logic [NCH*W-1:0]     ch_data;
    logic                 mux_dval;
    logic [W-1:0]         mux_data;
    logic [1:0]           mux_ch;
    logic                 busy;
    logic [NCH-1:0]       tmo_pulse;
    logic [NCH*8-1:0]     ovf_cnt;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   ch;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   strobes = 0;

    tdc_pair_scheduler #(.NCH(NCH), .W(W), .SETTLE(3), .TMO(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ch_dval   (ch_dval),
        .ch_data   (ch_data),
        .mux_dval  (mux_dval),
        .mux_data  (mux_data),
        .mux_ch    (mux_ch),
        .busy      (busy),
        .tmo_pulse (tmo_pulse),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic [1:0] ch);
        exp_t e;
        e.d  = d;
        e.ch = ch;
        sb.push_back(e);
    endtask

    // One clock; every strobe seen is matched against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (mux_dval === 1'b1) begin
            strobes++;
            $display("strobe ch=%0d data=%0h", mux_ch, mux_data);
            chk("strobe_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("strobe_data", 64'(mux_data), 64'(e.d));
                chk("strobe_ch", 64'(mux_ch), 64'(e.ch));
            end
        end
    endtask

    task automatic put(input int k, input logic [W-1:0] d);
        ch_dval[k[1:0]]  = 1'b1;
        ch_data[k*W +: W] = d;
        tick();
        ch_dval = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'(0));
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int s0;
        logic [NCH-1:0] tmo_seen;
        rst     = 1'b0;
        en      = 1'b0;
        ch_dval = '0;
        ch_data = '0;
        repeat (3) tick();
        chk("rst_mux_dval", 64'(mux_dval), 64'(0));
        chk("rst_mux_data", 64'(mux_data), 64'(0));
        chk("rst_mux_ch", 64'(mux_ch), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_tmo", 64'(tmo_pulse), 64'(0));
        chk("rst_ovf", 64'(ovf_cnt), 64'(0));
        rst = 1'b1;

        // Single pair on channel 0 with latency and settle timing.
        en = 1'b1;
        push(37'h10, 2'd0);
        push(37'h25, 2'd0);
        put(0, 37'h10);
        put(0, 37'h25);
        tick();
        chk("single_start_dval", 64'(mux_dval), 64'(1));
        chk("single_busy", 64'(busy), 64'(1));
        tick();
        chk("single_stop_dval", 64'(mux_dval), 64'(1));
        tick();
        chk("single_settle_dval", 64'(mux_dval), 64'(0));
        tick();
        tick();
        chk("single_settle_busy", 64'(busy), 64'(1));
        tick();
        chk("single_idle_busy", 64'(busy), 64'(0));
        chk("single_queue", 64'(sb.size()), 64'(0));

        // Fairness: all channels full at once, twice.
        do_reset();
        en = 1'b0;
        for (int k = 0; k < NCH; k++) ch_data[k*W +: W] = 37'h100 + 37'(k);
        ch_dval = '1;
        tick();
        for (int k = 0; k < NCH; k++) ch_data[k*W +: W] = 37'h200 + 37'(k);
        tick();
        ch_dval = '0;
        for (int k = 0; k < NCH; k++) begin
            push(37'h100 + 37'(k), 2'(k));
            push(37'h200 + 37'(k), 2'(k));
        end
        en = 1'b1;
        drain("fair1");
        for (int k = 0; k < NCH; k++) begin
            push(37'h300 + 37'(k), 2'(k));
            push(37'h400 + 37'(k), 2'(k));
        end
        for (int k = 0; k < NCH; k++) ch_data[k*W +: W] = 37'h300 + 37'(k);
        ch_dval = '1;
        tick();
        for (int k = 0; k < NCH; k++) ch_data[k*W +: W] = 37'h400 + 37'(k);
        tick();
        ch_dval = '0;
        drain("fair2");

        // Overflow on channel 2.
        en = 1'b0;
        for (int i = 0; i < 5; i++) put(2, 37'hA0 + 37'(i));
        chk("ovf_three", 64'(ovf_cnt[23:16]), 64'(3));
        chk("ovf_other", 64'(ovf_cnt[7:0]), 64'(0));
        push(37'hA0, 2'd2);
        push(37'hA1, 2'd2);
        en = 1'b1;
        drain("ovf1");
        en = 1'b0;
        put(2, 37'hB0);
        put(2, 37'hB1);
        push(37'hB0, 2'd2);
        push(37'hB1, 2'd2);
        for (int i = 0; i < 300; i++) begin
            ch_dval[2] = 1'b1;
            ch_data[2*W +: W] = 37'hC00 + 37'(i);
            tick();
        end
        ch_dval = '0;
        chk("ovf_saturate", 64'(ovf_cnt[23:16]), 64'(255));
        en = 1'b1;
        drain("ovf2");

        // Timeout on channel 1: lone start discarded after 10 cycles.
        put(1, 37'hD0);
        repeat (9) tick();
        chk("tmo_early", 64'(tmo_pulse), 64'(0));
        tick();
        chk("tmo_pulse", 64'(tmo_pulse), 64'(4'b0010));
        tick();
        chk("tmo_one_cycle", 64'(tmo_pulse), 64'(0));
        push(37'hE0, 2'd1);
        push(37'hE1, 2'd1);
        put(1, 37'hE0);
        put(1, 37'hE1);
        drain("tmo_empty");
        // Stop arriving in the expiry cycle completes the pair.
        push(37'hF0, 2'd1);
        push(37'hF1, 2'd1);
        put(1, 37'hF0);
        tmo_seen = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            tmo_seen = tmo_seen | tmo_pulse;
        end
        put(1, 37'hF1);
        tmo_seen = tmo_seen | tmo_pulse;
        tick();
        tmo_seen = tmo_seen | tmo_pulse;
        chk("tmo_stop_no_pulse", 64'(tmo_seen), 64'(0));
        drain("tmo_stop");

        // Grant collision on channel 3.
        en = 1'b0;
        push(37'h31, 2'd3);
        push(37'h32, 2'd3);
        put(3, 37'h31);
        put(3, 37'h32);
        en = 1'b1;
        put(3, 37'h33);
        drain("coll_pair");
        push(37'h33, 2'd3);
        push(37'h34, 2'd3);
        put(3, 37'h34);
        drain("coll_half");

        // Reset asserted while the start word is on the bus.
        en = 1'b0;
        put(1, 37'h51);
        put(1, 37'h52);
        push(37'h51, 2'd1);
        en = 1'b1;
        tick();
        chk("rst_mid_start", 64'(mux_dval), 64'(1));
        rst = 1'b0;
        #1;
        chk("rst_mid_dval", 64'(mux_dval), 64'(0));
        chk("rst_mid_data", 64'(mux_data), 64'(0));
        chk("rst_mid_ch", 64'(mux_ch), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_ovf", 64'(ovf_cnt), 64'(0));
        tick();
        tick();
        rst = 1'b1;
        s0 = strobes;
        repeat (12) tick();
        chk("rst_no_strobe", 64'(strobes - s0), 64'(0));
        chk("rst_final_busy", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
